grey_sobel_edge: RTL and testbench

Downstream stage of the greyscale converter. It consumes the registered grey pixel stream and its data-valid, frame-valid pair, and buffers two image lines to form a 3×3 window. It computes a Sobel gradient magnitude per interior pixel and emits the saturated magnitude, a thresholded edge flag, and the pixel's coordinates for the display/frame-buffer writer.

---
 rtl/grey_pkg.sv | 16 +
 rtl/grey_line_buffer.sv | 26 ++
 rtl/grey_sobel_edge.sv | 169 ++++++++++++++++
 tb/tb_grey_sobel_edge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/grey_pkg.sv
// Shared widths and helpers for the grey-pixel processing chain.
// The default grey width matches the upstream greyscale converter.
package grey_pkg;

    localparam int GREY_W = 12;
    localparam int GRAD_W = GREY_W + 3;
    localparam logic [GREY_W-1:0] GREY_MAX = '1;

    // Returns the number of bits needed to index `value` entries, never less than 1.
    function automatic int clog2(input int value);
        int w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/grey_line_buffer.sv
// Two-line pixel store, one entry per column: the upper half holds row r-2
// and the lower half holds row r-1. Reads are combinational so a write on the same edge sees old data.
module grey_line_buffer
    import grey_pkg::*;
#(
    parameter int WIDTH = 2 * GREY_W,
    parameter int DEPTH = 32,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             iclk,
    input  logic             iwe,
    input  logic [AW-1:0]    iaddr,
    input  logic [WIDTH-1:0] iwdata,
    output logic [WIDTH-1:0] ordata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign ordata = mem_q[iaddr];

    // NOTE: storage arrays get no reset; row gating upstream keeps stale contents from ever reaching an output.
    always_ff @(posedge iclk) begin
        if (iwe) mem_q[iaddr] <= iwdata;
    end

endmodule

// File: rtl/grey_sobel_edge.sv
// 3x3 Sobel gradient magnitude over the registered grey stream, emitting the
// saturated |Gx|+|Gy|, a threshold flag and the window-centre coordinates.
module grey_sobel_edge
    import grey_pkg::*;
#(
    parameter int num_rows      = 32,
    parameter int num_cols      = 32,
    parameter int num_bits_grey = GREY_W
) (
    input  logic                         iclk,
    input  logic                         irst_n,
    input  logic [num_bits_grey-1:0]     igrey,
    input  logic                         id_val,
    input  logic                         if_val,
    input  logic [num_bits_grey-1:0]     ithreshold,
    output logic [num_bits_grey-1:0]     omag,
    output logic                         oedge,
    output logic [clog2(num_cols)-1:0]   ox_pos,
    output logic [clog2(num_rows)-1:0]   oy_pos,
    output logic                         oVAL
);

    localparam int CW = clog2(num_cols);
    localparam int RW = clog2(num_rows);
    localparam int GW = num_bits_grey;
    localparam int SW = GW + 2;
    localparam int DW = GW + GRAD_W - GREY_W;
    localparam logic [CW-1:0] LAST_COL = CW'(num_cols - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(num_rows - 1);
    localparam logic [DW-1:0] MAG_MAX  = DW'((1 << GW) - 1);

    function automatic logic [SW-1:0] tap_sum(input logic [GW-1:0] a, b, c);
        return SW'(a) + (SW'(b) << 1) + SW'(c);
    endfunction

    logic                 fv_q, fv_d, done_q, done_d;
    logic [CW-1:0]        col_q, col_d, cur_col;
    logic [RW-1:0]        row_q, row_d, cur_row;
    logic                 frame_start, cur_done, accept;
    logic [GW-1:0]        win_q [3][3];
    logic [GW-1:0]        win_d [3][3];
    logic [2*GW-1:0]      lb_rdata;
    logic                 s1_val_q, s1_val_d, s2_val_q, s2_val_d, oval_q, oval_d;
    logic [CW-1:0]        s1_x_q, s1_x_d, s2_x_q, s2_x_d, ox_q, ox_d;
    logic [RW-1:0]        s1_y_q, s1_y_d, s2_y_q, s2_y_d, oy_q, oy_d;
    logic signed [DW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic [SW-1:0]        sum_gx_pos, sum_gx_neg, sum_gy_pos, sum_gy_neg;
    logic [DW-1:0]        abs_x, abs_y, mag;
    logic [GW-1:0]        sat, omag_q, omag_d;
    logic                 oedge_q, oedge_d;

    grey_line_buffer #(.WIDTH(2 * GW), .DEPTH(num_cols)) u_line_buffer (
        .iclk   (iclk),
        .iwe    (accept),
        .iaddr  (cur_col),
        .iwdata ({lb_rdata[GW-1:0], igrey}),
        .ordata (lb_rdata)
    );

    // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        // A rising frame-valid restarts at (0,0) even if the counters have not cleared yet.
        frame_start = if_val & ~fv_q;
        cur_col     = frame_start ? '0 : col_q;
        cur_row     = frame_start ? '0 : row_q;
        cur_done    = frame_start ? 1'b0 : done_q;
        accept      = if_val & id_val & ~cur_done;

        fv_d   = if_val;
        col_d  = cur_col;
        row_d  = cur_row;
        done_d = cur_done;
        win_d  = win_q;
        if (!if_val) begin
            col_d  = '0;
            row_d  = '0;
            done_d = 1'b0;
        end else if (accept) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                if (cur_row == LAST_ROW) done_d = 1'b1;
                else                     row_d  = cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_rdata[2*GW-1:GW];
            win_d[1][2] = lb_rdata[GW-1:0];
            win_d[2][2] = igrey;
        end

        s1_val_d = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        s1_x_d   = s1_val_d ? cur_col - CW'(1) : s1_x_q;
        s1_y_d   = s1_val_d ? cur_row - RW'(1) : s1_y_q;

        sum_gx_pos = tap_sum(win_q[0][2], win_q[1][2], win_q[2][2]);
        sum_gx_neg = tap_sum(win_q[0][0], win_q[1][0], win_q[2][0]);
        sum_gy_pos = tap_sum(win_q[2][0], win_q[2][1], win_q[2][2]);
        sum_gy_neg = tap_sum(win_q[0][0], win_q[0][1], win_q[0][2]);
        s2_val_d   = s1_val_q;
        gx_d = s1_val_q ? $signed({1'b0, sum_gx_pos}) - $signed({1'b0, sum_gx_neg}) : gx_q;
        gy_d = s1_val_q ? $signed({1'b0, sum_gy_pos}) - $signed({1'b0, sum_gy_neg}) : gy_q;
        s2_x_d = s1_val_q ? s1_x_q : s2_x_q;
        s2_y_d = s1_val_q ? s1_y_q : s2_y_q;

        abs_x   = gx_q[DW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        abs_y   = gy_q[DW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag     = abs_x + abs_y;
        sat     = (mag > MAG_MAX) ? MAG_MAX[GW-1:0] : mag[GW-1:0];
        oval_d  = s2_val_q;
        omag_d  = s2_val_q ? sat : omag_q;
        oedge_d = s2_val_q ? (sat >= ithreshold) : oedge_q;
        ox_d    = s2_val_q ? s2_x_q : ox_q;
        oy_d    = s2_val_q ? s2_y_q : oy_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            fv_q     <= 1'b0;
            done_q   <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '{default: '0};
            s1_val_q <= 1'b0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s2_val_q <= 1'b0;
            s2_x_q   <= '0;
            s2_y_q   <= '0;
            gx_q     <= '0;
            gy_q     <= '0;
            oval_q   <= 1'b0;
            omag_q   <= '0;
            oedge_q  <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
        end else begin
            fv_q     <= fv_d;
            done_q   <= done_d;
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            s1_val_q <= s1_val_d;
            s1_x_q   <= s1_x_d;
            s1_y_q   <= s1_y_d;
            s2_val_q <= s2_val_d;
            s2_x_q   <= s2_x_d;
            s2_y_q   <= s2_y_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            oval_q   <= oval_d;
            omag_q   <= omag_d;
            oedge_q  <= oedge_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
        end
    end

    assign omag   = omag_q;
    assign oedge  = oedge_q;
    assign ox_pos = ox_q;
    assign oy_pos = oy_q;
    assign oVAL   = oval_q;

endmodule

// File: tb/tb_grey_sobel_edge.sv
// Scoreboard bench for grey_sobel_edge on an 8x6 frame: the driver pushes image-level
// Sobel results, the monitor pops one per oVAL pulse and checks value, position and timing.
module tb_grey_sobel_edge;
    import grey_pkg::*;

    localparam int NC = 8;
    localparam int NR = 6;

    typedef struct {
        int mag;
        int edg;
        int x;
        int y;
        int when;
    } exp_t;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic [11:0] igrey;
    logic        id_val;
    logic        if_val;
    logic [11:0] ithreshold;
    logic [11:0] omag;
    logic        oedge;
    logic [2:0]  ox_pos;
    logic [2:0]  oy_pos;
    logic        oVAL;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   img [NR][NC];
    exp_t sb [$];

    grey_sobel_edge #(.num_rows(NR), .num_cols(NC), .num_bits_grey(12)) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .igrey      (igrey),
        .id_val     (id_val),
        .if_val     (if_val),
        .ithreshold (ithreshold),
        .omag       (omag),
        .oedge      (oedge),
        .ox_pos     (ox_pos),
        .oy_pos     (oy_pos),
        .oVAL       (oVAL)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: Sobel result centred on image pixel (y, x), straight from the picture.
    function automatic exp_t model(input int y, input int x, input int when);
        exp_t e;
        int gx, gy, m;
        gx = (img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1])
           - (img[y-1][x-1] + 2*img[y][x-1] + img[y+1][x-1]);
        gy = (img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1])
           - (img[y-1][x-1] + 2*img[y-1][x] + img[y-1][x+1]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > int'(GREY_MAX)) m = int'(GREY_MAX);
        e.mag  = m;
        e.edg  = (m >= int'(ithreshold)) ? 1 : 0;
        e.x    = x;
        e.y    = y;
        e.when = when;
        return e;
    endfunction

    // mode 0: back-to-back, 1: every other cycle plus a 10-cycle gap, 2: random gaps.
    task automatic send_frame(input int npix, input int mode, input int extra, input bit drop);
        int r, c, idle;
        for (int k = 0; k < npix; k++) begin
            r = k / NC;
            c = k % NC;
            if_val = 1'b1;
            id_val = 1'b1;
            igrey  = 12'(img[r][c]);
            if (r >= 2 && c >= 2) sb.push_back(model(r - 1, c - 1, cyc + 3));
            @(negedge iclk);
            id_val = 1'b0;
            igrey  = 12'($urandom);
            idle = 0;
            if (mode == 1) idle = (k == 28) ? 11 : 1;
            if (mode == 2) idle = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            repeat (idle) @(negedge iclk);
        end
        for (int k = 0; k < extra; k++) begin
            id_val = 1'b1;
            igrey  = 12'($urandom);
            @(negedge iclk);
            id_val = 1'b0;
        end
        if (drop) begin
            if_val = 1'b0;
            repeat (3) @(negedge iclk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge iclk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic fill_flat(input int v);
        for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) img[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) img[r][c] = int'($urandom_range(0, 4095));
    endtask

    initial begin : monitor
        exp_t e;
        logic [18:0] last = '0;
        forever begin
            @(negedge iclk);
            if (!irst_n) begin
                last = '0;
            end else if (oVAL) begin
                check("sb_has_entry", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("omag", omag, e.mag);
                    check("oedge", oedge, e.edg);
                    check("ox_pos", ox_pos, e.x);
                    check("oy_pos", oy_pos, e.y);
                    check("latency_cycle", cyc, e.when);
                end
                last = {omag, oedge, ox_pos, oy_pos};
            end else begin
                check("hold_outputs", {omag, oedge, ox_pos, oy_pos}, last);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : stimulus
        irst_n     = 1'b0;
        igrey      = '0;
        id_val     = 1'b0;
        if_val     = 1'b0;
        ithreshold = '0;
        repeat (3) @(negedge iclk);
        check("rst_omag", omag, 0);
        check("rst_oedge", oedge, 0);
        check("rst_ox", ox_pos, 0);
        check("rst_oy", oy_pos, 0);
        check("rst_oval", oVAL, 0);
        #2 irst_n = 1'b1;
        @(negedge iclk);

        // Flat frame, with extra pixels past the last row that must be ignored.
        fill_flat(100);
        ithreshold = 12'd1;
        send_frame(NR * NC, 0, 5, 1'b1);
        drain();

        // Vertical step.
        for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) img[r][c] = (c >= 4) ? 1000 : 0;
        ithreshold = 12'd2000;
        send_frame(NR * NC, 0, 0, 1'b1);
        drain();

        // Same vertical step with gapped pixel valid.
        send_frame(NR * NC, 1, 0, 1'b1);
        drain();

        // Horizontal step driving saturation.
        for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) img[r][c] = (r >= 3) ? 4095 : 0;
        send_frame(NR * NC, 0, 0, 1'b1);
        drain();

        // Frame abandoned after three rows, then a fresh full frame.
        fill_random();
        ithreshold = 12'($urandom_range(0, 4095));
        send_frame(3 * NC, 0, 0, 1'b1);
        fill_random();
        send_frame(NR * NC, 0, 0, 1'b1);
        drain();

        // Reset pulsed mid-frame.
        fill_random();
        send_frame(30, 0, 0, 1'b0);
        #2 irst_n = 1'b0;
        #1;
        check("midrst_omag", omag, 0);
        check("midrst_oedge", oedge, 0);
        check("midrst_ox", ox_pos, 0);
        check("midrst_oy", oy_pos, 0);
        check("midrst_oval", oVAL, 0);
        sb.delete();
        if_val = 1'b0;
        id_val = 1'b0;
        repeat (3) @(negedge iclk);
        #2 irst_n = 1'b1;
        @(negedge iclk);
        fill_flat(100);
        ithreshold = 12'd1;
        send_frame(NR * NC, 0, 0, 1'b1);
        drain();

        // Random frames with random gaps and thresholds.
        for (int f = 0; f < 6; f++) begin
            fill_random();
            ithreshold = 12'($urandom_range(0, 4095));
            send_frame(NR * NC, 2, int'($urandom_range(0, 3)), 1'b1);
            drain();
        end

        repeat (5) @(negedge iclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
